// File: rtl/pif_xi_master.sv
// Bridges the I2C slave byte stream onto the PIF register bus: the first byte after a
// start selects the register, later bytes are write data, reads return XO after its lag.
module pif_xi_master #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned SUBA_W = 4,
  parameter int unsigned DATA_W = 6
) (
  input  logic              xclk,
  input  logic              sys_rst,
  input  logic              i2c_start,
  input  logic              i2c_stop,
  input  logic              i2c_wr_vld,
  input  logic [7:0]        i2c_wr_data,
  input  logic              i2c_rd_req,
  output logic [7:0]        i2c_rd_data,
  output logic              i2c_rd_vld,
  output logic              XI_PWr,
  output logic [ADDR_W-1:0] XI_PRWA,
  output logic [DATA_W-1:0] XI_PD,
  output logic [SUBA_W-1:0] XI_PRdSubA,
  output logic              XI_PRdFinished,
  input  logic [7:0]        XO,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, GET_ADDR, ACTIVE, RD_WAIT} state_t;

  state_t            state_q, state_d;
  logic              rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] prwa_d;
  logic [DATA_W-1:0] pd_d;
  logic [SUBA_W-1:0] suba_d;
  logic [7:0]        rd_data_d;
  logic              pwr_d, fin_d, rd_vld_d, busy_d, err_d;

  // Only the low ADDR_W/DATA_W bits of a host byte carry meaning.
  logic unused_wr_bits;
  assign unused_wr_bits = ^i2c_wr_data;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    prwa_d    = XI_PRWA;
    pd_d      = XI_PD;
    suba_d    = XI_PRdSubA;
    rd_data_d = i2c_rd_data;
    pwr_d     = 1'b0;
    fin_d     = 1'b0;
    rd_vld_d  = 1'b0;
    busy_d    = 1'b0;
    err_d     = err;

    case (state_q)
      IDLE: begin
        if (i2c_start) state_d = GET_ADDR;
      end

      GET_ADDR, ACTIVE: begin
        if (i2c_start) begin
          state_d = GET_ADDR;
        end else if (i2c_rd_req) begin
          state_d  = RD_WAIT;
          rd_cnt_d = 1'b0;
          busy_d   = 1'b1;
        end else begin
          // A byte arriving with stop is still consumed before going idle.
          if (i2c_wr_vld) begin
            if (state_q == GET_ADDR) begin
              prwa_d  = i2c_wr_data[ADDR_W-1:0];
              suba_d  = '0;
              state_d = ACTIVE;
            end else begin
              pd_d  = i2c_wr_data[DATA_W-1:0];
              pwr_d = 1'b1;
            end
          end
          if (i2c_stop) state_d = IDLE;
        end
      end

      RD_WAIT: begin
        busy_d = 1'b1;
        if (i2c_wr_vld || i2c_rd_req || i2c_start || i2c_stop) err_d = 1'b1;
        if (!rd_cnt_q) begin
          rd_cnt_d = 1'b1;
        end else begin
          rd_data_d = XO;
          rd_vld_d  = 1'b1;
          fin_d     = 1'b1;
          suba_d    = XI_PRdSubA + SUBA_W'(1);
          state_d   = ACTIVE;
        end
      end
    endcase
  end

  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      rd_cnt_q       <= 1'b0;
      XI_PWr         <= 1'b0;
      XI_PRWA        <= '0;
      XI_PD          <= '0;
      XI_PRdSubA     <= '0;
      XI_PRdFinished <= 1'b0;
      i2c_rd_data    <= '0;
      i2c_rd_vld     <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_cnt_q       <= rd_cnt_d;
      XI_PWr         <= pwr_d;
      XI_PRWA        <= prwa_d;
      XI_PD          <= pd_d;
      XI_PRdSubA     <= suba_d;
      XI_PRdFinished <= fin_d;
      i2c_rd_data    <= rd_data_d;
      i2c_rd_vld     <= rd_vld_d;
      busy           <= busy_d;
      err            <= err_d;
    end
  end

endmodule

// File: tb/tb_pif_xi_master.sv
// Bench for pif_xi_master: cycle table, directed read corner cases, and random
// transactions checked against a transaction-level model with a lagged register file.
module tb_pif_xi_master;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned SUBA_W = 4;
  localparam int unsigned DATA_W = 6;

  logic              xclk = 1'b0;
  logic              sys_rst;
  logic              i2c_start, i2c_stop, i2c_wr_vld, i2c_rd_req;
  logic [7:0]        i2c_wr_data;
  logic [7:0]        i2c_rd_data;
  logic              i2c_rd_vld;
  logic              XI_PWr;
  logic [ADDR_W-1:0] XI_PRWA;
  logic [DATA_W-1:0] XI_PD;
  logic [SUBA_W-1:0] XI_PRdSubA;
  logic              XI_PRdFinished;
  logic [7:0]        XO;
  logic              busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 xclk = ~xclk;

  pif_xi_master #(.ADDR_W(ADDR_W), .SUBA_W(SUBA_W), .DATA_W(DATA_W)) dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_wr_vld(i2c_wr_vld), .i2c_wr_data(i2c_wr_data),
    .i2c_rd_req(i2c_rd_req), .i2c_rd_data(i2c_rd_data), .i2c_rd_vld(i2c_rd_vld),
    .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA), .XI_PD(XI_PD), .XI_PRdSubA(XI_PRdSubA),
    .XI_PRdFinished(XI_PRdFinished), .XO(XO), .busy(busy), .err(err)
  );

  // Register file contents seen by the bridge, presented two clocks after the address.
  function automatic logic [7:0] reg_val(input int unsigned a, input int unsigned s);
    int unsigned v;
    v = a * 37 + s * 11 + 5;
    return v[7:0];
  endfunction

  logic [7:0] xo_p1;
  always @(posedge xclk) begin
    xo_p1 <= reg_val(32'(XI_PRWA), 32'(XI_PRdSubA));
    XO    <= xo_p1;
  end

  // Transaction-level model: phase 0 idle, 1 expecting address, 2 address known.
  int unsigned m_addr, m_pd, m_suba, m_phase;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge xclk);
    #1;
  endtask

  task automatic clear_in();
    i2c_start   = 1'b0;
    i2c_stop    = 1'b0;
    i2c_wr_vld  = 1'b0;
    i2c_rd_req  = 1'b0;
    i2c_wr_data = 8'h00;
  endtask

  task automatic check_quiet(input string name, input bit pwr_exp);
    chk({name, ".pwr"},  32'(XI_PWr),         32'(pwr_exp));
    chk({name, ".prwa"}, 32'(XI_PRWA),        m_addr);
    chk({name, ".pd"},   32'(XI_PD),          m_pd);
    chk({name, ".suba"}, 32'(XI_PRdSubA),     m_suba);
    chk({name, ".busy"}, 32'(busy),           0);
    chk({name, ".rvld"}, 32'(i2c_rd_vld),     0);
    chk({name, ".fin"},  32'(XI_PRdFinished), 0);
    chk({name, ".err"},  32'(err),            32'(m_err));
  endtask

  task automatic do_reset(input string name);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    m_addr = 0; m_pd = 0; m_suba = 0; m_phase = 0; m_err = 1'b0;
    chk({name, ".rdata"}, 32'(i2c_rd_data), 0);
    check_quiet(name, 1'b0);
  endtask

  // One input cycle of start/stop/byte traffic, then the outputs it produced.
  task automatic step(input string name, input bit st, input bit sp, input bit wv,
                      input logic [7:0] wd);
    bit pwr_exp;
    pwr_exp     = 1'b0;
    i2c_start   = st;
    i2c_stop    = sp;
    i2c_wr_vld  = wv;
    i2c_wr_data = wd;
    tick();
    clear_in();
    if (st) begin
      m_phase = 1;
    end else if (m_phase != 0) begin
      if (wv) begin
        if (m_phase == 1) begin
          m_addr  = int'(wd) % (1 << ADDR_W);
          m_suba  = 0;
          m_phase = 2;
        end else begin
          m_pd    = int'(wd) % (1 << DATA_W);
          pwr_exp = 1'b1;
        end
      end
      if (sp) m_phase = 0;
    end
    check_quiet(name, pwr_exp);
  endtask

  // Read request; drop_kind 1:wr_vld@N+1 2:rd_req@N+2 3:start@N+1 4:stop@N+2 (all must be ignored).
  task automatic do_read(input string name, input int drop_kind);
    logic [7:0] exp_data;
    if (m_phase == 0) begin
      i2c_rd_req = 1'b1;
      tick();
      clear_in();
      check_quiet({name, ".idle"}, 1'b0);
      return;
    end
    exp_data   = reg_val(m_addr, m_suba);
    i2c_rd_req = 1'b1;
    tick();
    clear_in();
    for (int c = 1; c <= 3; c++) begin
      chk({name, ".busy"}, 32'(busy),           1);
      chk({name, ".rvld"}, 32'(i2c_rd_vld),     32'(c == 3));
      chk({name, ".fin"},  32'(XI_PRdFinished), 32'(c == 3));
      chk({name, ".pwr"},  32'(XI_PWr),         0);
      chk({name, ".pd"},   32'(XI_PD),          m_pd);
      chk({name, ".err"},  32'(err),            32'(m_err));
      if (c == 3) begin
        chk({name, ".rdata"}, 32'(i2c_rd_data), 32'(exp_data));
        chk({name, ".suba"},  32'(XI_PRdSubA),  (m_suba + 1) % (1 << SUBA_W));
      end else begin
        chk({name, ".suba_hold"}, 32'(XI_PRdSubA), m_suba);
        if (drop_kind == 1 && c == 1) begin i2c_wr_vld = 1'b1; i2c_wr_data = 8'h2F; m_err = 1'b1; end
        if (drop_kind == 2 && c == 2) begin i2c_rd_req = 1'b1; m_err = 1'b1; end
        if (drop_kind == 3 && c == 1) begin i2c_start = 1'b1; m_err = 1'b1; end
        if (drop_kind == 4 && c == 2) begin i2c_stop = 1'b1; m_err = 1'b1; end
      end
      tick();
      clear_in();
    end
    m_suba  = (m_suba + 1) % (1 << SUBA_W);
    m_phase = 2;
    check_quiet({name, ".after"}, 1'b0);
  endtask

  typedef struct {
    bit               st, sp, wv, rr;
    logic [7:0]       wd;
    logic             pwr;
    logic [ADDR_W-1:0] prwa;
    logic [DATA_W-1:0] pd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    clear_in();
    sys_rst = 1'b1;
    repeat (2) tick();
    do_reset("reset");

    vecs = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'h00, 6'h00},  // start
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 6'h03, 6'h00},  // address byte
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h2A, 1'b1, 6'h03, 6'h2A},  // data byte
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'h03, 6'h2A},  // strobe is one cycle
      '{1'b0, 1'b1, 1'b1, 1'b0, 8'h15, 1'b1, 6'h03, 6'h15},  // data + stop: written
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h3F, 1'b0, 6'h03, 6'h15},  // idle: byte ignored
      '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 6'h03, 6'h15},  // idle: rd_req ignored
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'h03, 6'h15},  // start + stop: start wins
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 1'b0, 6'h07, 6'h15},  // taken as address
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'hC5, 1'b1, 6'h07, 6'h05},  // data truncated to 6 bits
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'h07, 6'h05},  // repeated start
      '{1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 6'h3C, 6'h05},  // address + stop
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 6'h3C, 6'h05},  // idle: byte ignored
      '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 6'h3C, 6'h05}   // idle: rd_req ignored
    };
    for (int i = 0; i < 14; i++) begin
      i2c_start   = vecs[i].st;
      i2c_stop    = vecs[i].sp;
      i2c_wr_vld  = vecs[i].wv;
      i2c_rd_req  = vecs[i].rr;
      i2c_wr_data = vecs[i].wd;
      tick();
      clear_in();
      chk($sformatf("vec%0d.pwr", i),  32'(XI_PWr),     32'(vecs[i].pwr));
      chk($sformatf("vec%0d.prwa", i), 32'(XI_PRWA),    32'(vecs[i].prwa));
      chk($sformatf("vec%0d.pd", i),   32'(XI_PD),      32'(vecs[i].pd));
      chk($sformatf("vec%0d.suba", i), 32'(XI_PRdSubA), 0);
      chk($sformatf("vec%0d.busy", i), 32'(busy),       0);
      chk($sformatf("vec%0d.err", i),  32'(err),        0);
    end

    // Basic read after addressing register 1.
    do_reset("reset2");
    step("rd.start", 1'b1, 1'b0, 1'b0, 8'h00);
    step("rd.addr",  1'b0, 1'b0, 1'b1, 8'h01);
    do_read("read0", 0);

    // Sub-address walks 0..15 and wraps to 0.
    step("wrap.start", 1'b1, 1'b0, 1'b0, 8'h00);
    step("wrap.addr",  1'b0, 1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrap.pre%0d", i), 32'(XI_PRdSubA), 32'(i));
      do_read($sformatf("wrap%0d", i), 0);
    end
    chk("wrap.final", 32'(XI_PRdSubA), 0);

    // Traffic during a read is dropped and flagged; err stays set afterwards.
    for (int k = 1; k <= 4; k++) begin
      do_reset($sformatf("drop%0d.reset", k));
      step($sformatf("drop%0d.start", k), 1'b1, 1'b0, 1'b0, 8'h00);
      step($sformatf("drop%0d.addr", k),  1'b0, 1'b0, 1'b1, 8'h05);
      do_read($sformatf("drop%0d", k), k);
      step($sformatf("drop%0d.wr", k),    1'b0, 1'b0, 1'b1, 8'h12);
      chk($sformatf("drop%0d.sticky", k), 32'(err), 1);
    end

    // Reset during the first wait cycle of a read aborts it silently.
    do_reset("abort.reset");
    step("abort.start", 1'b1, 1'b0, 1'b0, 8'h00);
    step("abort.addr",  1'b0, 1'b0, 1'b1, 8'h09);
    do_read("abort.pre", 0);
    step("abort.data",  1'b0, 1'b0, 1'b1, 8'h33);
    i2c_rd_req = 1'b1;
    tick();
    clear_in();
    chk("abort.busy_w1", 32'(busy), 1);
    do_reset("abort.rst");
    for (int i = 0; i < 3; i++) check_quiet($sformatf("abort.post%0d", i), 1'b0);
    tick();
    check_quiet("abort.post_tick1", 1'b0);
    tick();
    check_quiet("abort.post_tick2", 1'b0);

    // Random transactions against the model.
    do_reset("rand.reset");
    for (int n = 0; n < 400; n++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1:       step("rand.start", 1'b1, ($urandom_range(0, 3) == 0), 1'b0, 8'h00);
        2, 3, 4, 5: step("rand.wr", 1'b0, ($urandom_range(0, 4) == 0), 1'b1, 8'($urandom_range(0, 255)));
        6:          step("rand.stop", 1'b0, 1'b1, 1'b0, 8'h00);
        7, 8: begin
          int d;
          d = int'($urandom_range(0, 9));
          do_read("rand.read", (d > 4) ? 0 : d);
        end
        default:    step("rand.nop", 1'b0, 1'b0, 1'b0, 8'h00);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pif_xi_master.md
PIF_XI_MASTER -- requirements
Module: pif_xi_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, width of XI_PRWA (matches `TXA+1 in pifdefs.v).
REQ-002 SHALL have parameter SUBA_W, default 4, width of XI_PRdSubA (matches `TXSubA+1).
REQ-003 SHALL have parameter DATA_W, default 6, width of XI_PD (matches `I2C_DATA_BITS).
REQ-004 SHALL have port xclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port i2c_start, input, 1, one-cycle pulse: (repeated) start seen.
REQ-007 SHALL have port i2c_stop, input, 1, one-cycle pulse: stop seen.
REQ-008 SHALL have port i2c_wr_vld, input, 1, one-cycle pulse: byte received from host.
REQ-009 SHALL have port i2c_wr_data, input, 8, received byte, valid with i2c_wr_vld.
REQ-010 SHALL have port i2c_rd_req, input, 1, one-cycle pulse: host needs a byte.
REQ-011 SHALL have port i2c_rd_data, output, 8, byte for host, valid with i2c_rd_vld.
REQ-012 SHALL have port i2c_rd_vld, output, 1, one-cycle pulse: i2c_rd_data valid.
REQ-013 SHALL have port XI_PWr, output, 1, single-clock register write strobe.
REQ-014 SHALL have port XI_PRWA, output, ADDR_W, registered register address.
REQ-015 SHALL have port XI_PD, output, DATA_W, registered write data.
REQ-016 SHALL have port XI_PRdSubA, output, SUBA_W, read sub-address.
REQ-017 SHALL have port XI_PRdFinished, output, 1, one-cycle pulse: read byte consumed.
REQ-018 SHALL have port XO, input, 8, register readback; lags XI_PRWA/XI_PRdSubA by 2 xclk.
REQ-019 SHALL have port busy, output, 1, high while a read is in flight.
REQ-020 SHALL have port err, output, 1, sticky: byte or rd_req dropped while busy.

Function
REQ-021 SHALL implement FSM states IDLE, GET_ADDR, ACTIVE, RD_WAIT; all outputs registered.
REQ-022 SHALL, from any state except RD_WAIT, go to GET_ADDR on i2c_start.
REQ-023 SHALL, in GET_ADDR on i2c_wr_vld, load XI_PRWA <= i2c_wr_data[ADDR_W-1:0], clear XI_PRdSubA to 0, go to ACTIVE.
REQ-024 SHALL, in ACTIVE on i2c_wr_vld, load XI_PD <= i2c_wr_data[DATA_W-1:0] and assert XI_PWr for exactly the next cycle, with XI_PRWA unchanged.
REQ-025 SHALL, in GET_ADDR or ACTIVE on i2c_rd_req, enter RD_WAIT using held XI_PRWA/XI_PRdSubA (repeated-start read allowed).
REQ-026 SHALL stay in RD_WAIT exactly 2 cycles, capture XO into i2c_rd_data on the 3rd cycle, and pulse i2c_rd_vld that same cycle (rd_req at cycle N -> rd_vld at N+3).
REQ-027 SHALL, on the capture cycle, pulse XI_PRdFinished for one cycle, increment XI_PRdSubA modulo 2**SUBA_W (15 -> 0), and return to ACTIVE.
REQ-028 SHALL hold busy high from the cycle after rd_req through the capture cycle inclusive.
REQ-029 SHALL ignore i2c_wr_vld, i2c_rd_req, i2c_start and i2c_stop in RD_WAIT and set err on any of them; the read completes normally.
REQ-030 SHALL, on i2c_stop in GET_ADDR/ACTIVE, go to IDLE; XI_PRWA, XI_PRdSubA, XI_PD retained.
REQ-031 SHALL process i2c_wr_vld first when coincident with i2c_stop, then enter IDLE.
REQ-032 SHALL let i2c_start win over i2c_stop when coincident.
REQ-033 SHALL ignore i2c_wr_vld and i2c_rd_req in IDLE (no err).
REQ-034 SHALL never assert XI_PWr and XI_PRdFinished in the same cycle.

Reset
REQ-035 SHALL, on sys_rst high at a clock edge, set state IDLE, XI_PWr=0, XI_PRWA=0, XI_PD=0, XI_PRdSubA=0, XI_PRdFinished=0, i2c_rd_data=0, i2c_rd_vld=0, busy=0, err=0.
REQ-036 SHALL, on reset mid-read, abort with no i2c_rd_vld or XI_PRdFinished pulse.
REQ-037 SHALL clear err only by reset.

Verification
REQ-038 SHALL cover write: start, wr 0x03, wr 0x2A -> XI_PRWA=3, XI_PD=0x2A, XI_PWr one cycle.
REQ-039 SHALL cover read: start, wr 0x01, rd_req at N with XO model delayed 2 cycles -> rd_vld at N+3, data=XO for subA 0, XI_PRdSubA=1, XI_PRdFinished one pulse.
REQ-040 SHALL cover wrap: 16 consecutive reads -> XI_PRdSubA sequence 0..15 then 0.
REQ-041 SHALL cover busy drop: wr_vld 1 cycle after rd_req -> byte ignored, XI_PWr stays 0, err=1, read completes.
REQ-042 SHALL cover stop+wr coincident and start+stop coincident -> REQ-031/REQ-032 outcomes.
REQ-043 SHALL cover reset at RD_WAIT cycle 1 -> no rd_vld, all outputs at REQ-035 values next cycle.
